// File: rtl/pipe_stage_hs_pkg.sv
// Shared FSM encoding and occupancy sizing for the pipe_stage_hs handshake stage.
package pipe_stage_hs_pkg;

   typedef enum logic [1:0] {
      PIPE_ST_EMPTY = 2'd0,
      PIPE_ST_ONE   = 2'd1,
      PIPE_ST_FULL  = 2'd2
   } pipe_st_e;

   localparam int PIPE_OCC_LEN = 2;

   function automatic logic [PIPE_OCC_LEN-1:0] st_to_occ(input pipe_st_e st);
      case (st)
         PIPE_ST_ONE:  st_to_occ = 2'd1;
         PIPE_ST_FULL: st_to_occ = 2'd2;
         default:      st_to_occ = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_hs_skid_buf.sv
// Two-entry skid storage with EMPTY/ONE/FULL FSM; only elaborated when PIPE_SKID_EN is defined.
// clr outranks hold, hold outranks the fire strobes supplied by the wrapper.
`ifdef PIPE_SKID_EN
module pipe_skid_buf
   import pipe_stage_hs_pkg::*;
#(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             hold,
   input  logic             in_fire,
   input  logic             out_fire,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic             head_vld_o,
   output logic             full_o,
   output logic [1:0]       occ_o
);

   pipe_st_e         st_q, st_d;
   logic [WIDTH-1:0] head_p0, head_d, skid_p0, skid_d;

   always_comb begin
      st_d   = st_q;
      head_d = head_p0;
      skid_d = skid_p0;
      if (clr) begin
         st_d   = PIPE_ST_EMPTY;
         head_d = RESET_VAL;
         skid_d = RESET_VAL;
      end else if (!hold) begin
         case (st_q)
            PIPE_ST_EMPTY: begin
               if (in_fire) begin
                  st_d   = PIPE_ST_ONE;
                  head_d = data_i;
               end
            end
            PIPE_ST_ONE: begin
               // Downstream blocked: the new beat parks in the skid entry behind the head
               if (in_fire && !out_fire) begin
                  st_d   = PIPE_ST_FULL;
                  skid_d = data_i;
               end else if (in_fire && out_fire) begin
                  head_d = data_i;
               end else if (out_fire) begin
                  st_d = PIPE_ST_EMPTY;
               end
            end
            PIPE_ST_FULL: begin
               if (out_fire) begin
                  st_d   = PIPE_ST_ONE;
                  head_d = skid_p0;
                  skid_d = RESET_VAL;
               end
            end
            default: st_d = PIPE_ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q    <= PIPE_ST_EMPTY;
         head_p0 <= RESET_VAL;
         skid_p0 <= RESET_VAL;
      end else begin
         st_q    <= st_d;
         head_p0 <= head_d;
         skid_p0 <= skid_d;
      end
   end

   assign head_o     = head_p0;
   assign head_vld_o = (st_q != PIPE_ST_EMPTY);
   assign full_o     = (st_q == PIPE_ST_FULL);
   assign occ_o      = st_to_occ(st_q);

endmodule
`endif

// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline-stage register with flush and stall; bubbles tracked by valid.
// PIPE_SKID_EN selects a 2-entry skid buffer with registered ready_o; otherwise a single entry.
module pipe_stage_hs
   import pipe_stage_hs_pkg::*;
#(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_valid_i,
   input  logic             stall_valid_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic [1:0]       occ_o
);

   logic in_fire, out_fire, head_vld;

   assign in_fire  = valid_i & ready_o;
   assign out_fire = valid_o & ready_i;
   assign valid_o  = head_vld & ~stall_valid_i;

`ifdef PIPE_SKID_EN
   logic full;

   // ready_o depends only on held state and stall, never on ready_i
   assign ready_o = ~full & ~stall_valid_i;

   pipe_skid_buf #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .clr        (flush_valid_i),
      .hold       (stall_valid_i),
      .in_fire    (in_fire),
      .out_fire   (out_fire),
      .data_i     (data_i),
      .head_o     (data_o),
      .head_vld_o (head_vld),
      .full_o     (full),
      .occ_o      (occ_o)
   );
`else
   pipe_st_e         st_q, st_d;
   logic [WIDTH-1:0] head_p0, head_d;

   assign ready_o = (~head_vld | ready_i) & ~stall_valid_i;

   always_comb begin
      st_d   = st_q;
      head_d = head_p0;
      if (flush_valid_i) begin
         st_d   = PIPE_ST_EMPTY;
         head_d = RESET_VAL;
      end else if (!stall_valid_i) begin
         if (in_fire) begin
            st_d   = PIPE_ST_ONE;
            head_d = data_i;
         end else if (out_fire) begin
            st_d = PIPE_ST_EMPTY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q    <= PIPE_ST_EMPTY;
         head_p0 <= RESET_VAL;
      end else begin
         st_q    <= st_d;
         head_p0 <= head_d;
      end
   end

   assign head_vld = (st_q == PIPE_ST_ONE);
   assign data_o   = head_p0;
   assign occ_o    = st_to_occ(st_q);
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed and scoreboard bench for pipe_stage_hs; builds for either PIPE_SKID_EN setting.
module tb_pipe_stage_hs;

   localparam int          WIDTH = 16;
   localparam logic [15:0] RV    = 16'hA5A5;
`ifdef PIPE_SKID_EN
   localparam logic [1:0]  MAXOCC = 2'd2;
`else
   localparam logic [1:0]  MAXOCC = 2'd1;
`endif

   logic        clk = 1'b0;
   logic        rst, flush_valid_i, stall_valid_i, valid_i, ready_i;
   logic        ready_o, valid_o;
   logic [15:0] data_i, data_o;
   logic [1:0]  occ_o;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   pipe_stage_hs #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush_valid_i (flush_valid_i),
      .stall_valid_i (stall_valid_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .data_i        (data_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .data_o        (data_o),
      .occ_o         (occ_o)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; flush_valid_i = 1'b0; stall_valid_i = 1'b0;
      valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
      repeat (2) cyc();
      vectors++;
      if ({valid_o, data_o, occ_o} !== {1'b0, RV, 2'd0}) begin
         errors++;
         $display("FAIL reset_state: got v=%0b d=%h occ=%0d, expected v=0 d=%h occ=0", valid_o, data_o, occ_o, RV);
      end
      rst = 1'b1;
      cyc();
      valid_i = 1'b1; data_i = 16'h1111;
      cyc();
      data_i = 16'h2222;
      cyc();
      valid_i = 1'b0;
      vectors++;
      if ({valid_o, data_o, occ_o} !== {1'b1, 16'h1111, MAXOCC}) begin
         errors++;
         $display("FAIL reset_preload: got v=%0b d=%h occ=%0d, expected v=1 d=1111 occ=%0d", valid_o, data_o, occ_o, MAXOCC);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({valid_o, data_o, occ_o} !== {1'b0, RV, 2'd0}) begin
         errors++;
         $display("FAIL reset_async: got v=%0b d=%h occ=%0d, expected v=0 d=%h occ=0", valid_o, data_o, occ_o, RV);
      end
      cyc();
      rst = 1'b1;
      #1;
      vectors++;
      if (ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %0b expected 1", ready_o);
      end
   endtask

   task automatic test_streaming();
      ready_i = 1'b1; valid_i = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         data_i = 16'(i);
         cyc();
         vectors++;
         if ({valid_o, data_o, occ_o} !== {1'b1, 16'(i), 2'd1}) begin
            errors++;
            $display("FAIL stream_%0d: got v=%0b d=%h occ=%0d, expected v=1 d=%h occ=1", i, valid_o, data_o, occ_o, 16'(i));
         end
      end
      valid_i = 1'b0;
      cyc();
      vectors++;
      if ({valid_o, occ_o} !== {1'b0, 2'd0}) begin
         errors++;
         $display("FAIL stream_drain: got v=%0b occ=%0d, expected v=0 occ=0", valid_o, occ_o);
      end
   endtask

   task automatic test_backpressure();
      ready_i = 1'b0; valid_i = 1'b1; data_i = 16'h0A0A;
      cyc();
      data_i = 16'h0B0B;
`ifdef PIPE_SKID_EN
      vectors++;
      if ({occ_o, ready_o} !== {2'd1, 1'b1}) begin
         errors++;
         $display("FAIL bp_one: got occ=%0d rdy=%0b, expected occ=1 rdy=1", occ_o, ready_o);
      end
      cyc();
      valid_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if ({valid_o, data_o, occ_o, ready_o} !== {1'b1, 16'h0A0A, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL bp_full_%0d: got v=%0b d=%h occ=%0d rdy=%0b, expected v=1 d=0a0a occ=2 rdy=0", k, valid_o, data_o, occ_o, ready_o);
         end
         cyc();
      end
      ready_i = 1'b1;
      cyc();
      vectors++;
      if ({valid_o, data_o, occ_o} !== {1'b1, 16'h0B0B, 2'd1}) begin
         errors++;
         $display("FAIL bp_second: got v=%0b d=%h occ=%0d, expected v=1 d=0b0b occ=1", valid_o, data_o, occ_o);
      end
`else
      #1;
      vectors++;
      if (ready_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_ready_low: got %0b expected 0", ready_o);
      end
      cyc();
      valid_i = 1'b0;
      vectors++;
      if ({valid_o, data_o, occ_o} !== {1'b1, 16'h0A0A, 2'd1}) begin
         errors++;
         $display("FAIL bp_hold: got v=%0b d=%h occ=%0d, expected v=1 d=0a0a occ=1", valid_o, data_o, occ_o);
      end
      ready_i = 1'b1;
      #1;
      vectors++;
      if (ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_comb: got %0b expected 1", ready_o);
      end
`endif
      cyc();
      vectors++;
      if ({valid_o, occ_o} !== {1'b0, 2'd0}) begin
         errors++;
         $display("FAIL bp_drain: got v=%0b occ=%0d, expected v=0 occ=0", valid_o, occ_o);
      end
   endtask

   task automatic test_stall();
      ready_i = 1'b0; valid_i = 1'b1; data_i = 16'hDEAD;
      cyc();
      stall_valid_i = 1'b1; ready_i = 1'b1; data_i = 16'hBEEF;
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++;
         if ({valid_o, ready_o} !== 2'b00) begin
            errors++;
            $display("FAIL stall_out_%0d: got v=%0b rdy=%0b, expected v=0 rdy=0", k, valid_o, ready_o);
         end
         cyc();
         vectors++;
         if ({data_o, occ_o} !== {16'hDEAD, 2'd1}) begin
            errors++;
            $display("FAIL stall_hold_%0d: got d=%h occ=%0d, expected d=dead occ=1", k, data_o, occ_o);
         end
      end
      stall_valid_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      #1;
      vectors++;
      if ({valid_o, data_o} !== {1'b1, 16'hDEAD}) begin
         errors++;
         $display("FAIL stall_release: got v=%0b d=%h, expected v=1 d=dead", valid_o, data_o);
      end
      ready_i = 1'b1;
      cyc();
      vectors++;
      if ({valid_o, occ_o} !== {1'b0, 2'd0}) begin
         errors++;
         $display("FAIL stall_drain: got v=%0b occ=%0d, expected v=0 occ=0", valid_o, occ_o);
      end
   endtask

   task automatic test_flush();
      ready_i = 1'b0; valid_i = 1'b1; data_i = 16'h1234;
      cyc();
      data_i = 16'h5678;
      cyc();
      flush_valid_i = 1'b1; ready_i = 1'b1; data_i = 16'h0055;
      cyc();
      flush_valid_i = 1'b0; valid_i = 1'b0;
      #1;
      vectors++;
      if ({valid_o, data_o, occ_o} !== {1'b0, RV, 2'd0}) begin
         errors++;
         $display("FAIL flush_clear: got v=%0b d=%h occ=%0d, expected v=0 d=%h occ=0", valid_o, data_o, occ_o, RV);
      end
      for (int k = 0; k < 3; k++) begin
         cyc();
         vectors++;
         if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_emit_%0d: got v=%0b d=%h, expected v=0", k, valid_o, data_o);
         end
      end
   endtask

   task automatic test_flush_stall();
      ready_i = 1'b0; valid_i = 1'b1; data_i = 16'h7777;
      cyc();
      valid_i = 1'b0; flush_valid_i = 1'b1; stall_valid_i = 1'b1;
      cyc();
      flush_valid_i = 1'b0; stall_valid_i = 1'b0;
      #1;
      vectors++;
      if ({valid_o, occ_o} !== {1'b0, 2'd0}) begin
         errors++;
         $display("FAIL flush_over_stall: got v=%0b occ=%0d, expected v=0 occ=0", valid_o, occ_o);
      end
   endtask

   task automatic test_random();
      logic [15:0] q[$];
      logic [15:0] nxt;
      int          got, ncyc;
      nxt = 16'h0001; got = 0; ncyc = 0;
      while (got < 10000 && ncyc < 60000) begin
         stall_valid_i = ($urandom_range(0, 9) == 0);
         valid_i       = ($urandom_range(0, 3) != 0);
         ready_i       = ($urandom_range(0, 2) != 0);
         data_i        = nxt;
         #1;
         if (valid_o && ready_i) begin
            vectors++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious: got d=%h with no beat outstanding", data_o);
            end else begin
               if (data_o !== q[0]) begin
                  errors++;
                  $display("FAIL rand_order: got d=%h expected d=%h", data_o, q[0]);
               end
               void'(q.pop_front());
            end
            got++;
         end
         if (valid_i && ready_o) begin
            q.push_back(nxt);
            nxt++;
         end
         cyc();
         ncyc++;
         vectors++;
         if (occ_o !== 2'(q.size())) begin
            errors++;
            $display("FAIL rand_occ: got %0d expected %0d at cycle %0d", occ_o, q.size(), ncyc);
         end
      end
      vectors++;
      if (got < 10000) begin
         errors++;
         $display("FAIL rand_timeout: got %0d beats expected 10000", got);
      end
      valid_i = 1'b0; stall_valid_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_stall();
      test_flush();
      test_flush_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
